// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length and the sequencing state encoding
// used by both the transmitter and the arbiter in front of it.
package uart_pkg;

  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } uart_state_e;

  function automatic int frame_clks(input int clks_per_bit, input int guard_clks);
    return UART_FRAME_BITS * clks_per_bit + guard_clks;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts just after the last grant
// and wraps, so every pending requester is served within NUM_REQ grants.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    gnt_o    = '0;
    idx_o    = last_i;
    valid_o  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers: grants round-robin in
// IDLE, pulses start, then holds off for one full frame plus guard time.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int GUARD_CLKS   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_tx_start,
  output logic [7:0]                 uart_tx_input,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int FRAME_CLKS = frame_clks(CLKS_PER_BIT, GUARD_CLKS);
  localparam int CNT_W      = $clog2(FRAME_CLKS);
  localparam int GID_W      = $clog2(NUM_REQ);

  uart_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic [GID_W-1:0]   gid_q, gid_d;

  logic [NUM_REQ-1:0] win_gnt;
  logic [GID_W-1:0]   win_idx;
  logic               win_any;
  logic [7:0]         win_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_rr (
    .req_i   (req_valid),
    .last_i  (gid_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .valid_o (win_any)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == GID_W'(i)) win_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    gid_d     = gid_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_any && !reset) begin
          req_ready = win_gnt;
          data_d    = win_byte;
          gid_d     = win_idx;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = CNT_W'(FRAME_CLKS - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Leaving as the count reaches zero keeps START-to-START at FRAME_CLKS+1.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      gid_q   <= GID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end

  assign uart_tx_start = (state_q == ST_START);
  assign busy          = (state_q != ST_IDLE);
  assign uart_tx_input = data_q;
  assign grant_id      = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a random
// phase, checked against a frame-timing model built from grant/hold rules.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int CPB   = 20;
  localparam int GUARD = 0;
  localparam int FRAME = 10 * CPB + GUARD;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [31:0]  req_data;
  logic [3:0]   req_ready;
  logic         uart_tx_start;
  logic [7:0]   uart_tx_input;
  logic [1:0]   grant_id;
  logic         busy;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .CLKS_PER_BIT (CPB),
    .GUARD_CLKS   (GUARD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .uart_tx_start (uart_tx_start),
    .uart_tx_input (uart_tx_input),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle_n = 0;

  // Model: last winner, remaining busy cycles of the current frame, captured byte.
  int         m_last;
  int         m_busy_left;
  logic [7:0] m_byte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int winner(input int last, input logic [3:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle against the model, advance the model, then step the clock.
  task automatic cyc();
    int         w;
    logic [3:0] exp_ready;
    #1;
    w = winner(m_last, req_valid);
    exp_ready = (m_busy_left == 0 && w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("ready", req_ready, exp_ready);
    chk("busy", busy, m_busy_left > 0);
    chk("start", uart_tx_start, m_busy_left == FRAME);
    if (m_busy_left == FRAME) begin
      chk("byte", uart_tx_input, m_byte);
      chk("gid", grant_id, m_last);
    end
    if (m_busy_left > 0) m_busy_left--;
    else if (w >= 0) begin
      m_last      = w;
      m_byte      = req_data[8*w +: 8];
      m_busy_left = FRAME;
    end
    cycle_n++;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      cyc();
    end
    chk("drain_timeout", busy, 1'b0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("ready_in_reset", req_ready, 4'b0000);
    tick();
    tick();
    reset       = 1'b0;
    req_valid   = 4'b0000;
    m_last      = N - 1;
    m_busy_left = 0;
    m_byte      = 8'h00;
  endtask

  initial begin
    int         n;
    int         ns;
    int         sc;
    int         st_cyc [5];
    int         st_gid [5];
    logic [7:0] st_byte [5];
    int         exp_gid [5];
    logic [7:0] exp_byte [5];
    exp_gid  = '{0, 1, 2, 3, 0};
    exp_byte = '{8'h34, 8'h55, 8'hA5, 8'h0F, 8'h34};

    reset     = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tick();
    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", uart_tx_start, 1'b0);
    chk("rst_input", uart_tx_input, 8'h00);
    chk("rst_gid", grant_id, 2'd3);

    // Single requester: same-cycle ready, start next cycle, 200 busy cycles.
    req_data[7:0] = 8'h34;
    req_valid     = 4'b0001;
    #1;
    chk("r23_ready", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    chk("r23_start", uart_tx_start, 1'b1);
    chk("r23_input", uart_tx_input, 8'h34);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      cyc();
    end
    chk("r23_busy_len", n, 200);

    // All four pending: order 0,1,2,3,0 with starts 201 cycles apart.
    do_reset();
    req_data  = 32'h0FA55534;
    req_valid = 4'b1111;
    ns = 0;
    n  = 0;
    while (ns < 5 && n < 1200) begin
      if (uart_tx_start === 1'b1) begin
        st_cyc[ns]  = cycle_n;
        st_gid[ns]  = int'(grant_id);
        st_byte[ns] = uart_tx_input;
        ns++;
      end
      n++;
      cyc();
    end
    chk("r24_starts", ns, 5);
    for (int i = 0; i < ns; i++) begin
      chk("r24_gid", st_gid[i], exp_gid[i]);
      chk("r24_byte", st_byte[i], exp_byte[i]);
      if (i > 0) chk("r24_spacing", st_cyc[i] - st_cyc[i-1], 201);
    end
    req_valid = 4'b0000;
    drain();

    // Wrap-around: from grant_id 3 requester 0 wins, then from 0 requester 3.
    do_reset();
    req_valid = 4'b1001;
    #1;
    chk("r25_wrap", req_ready, 4'b0001);
    cyc();
    drain();
    #1;
    chk("r25_next", req_ready, 4'b1000);
    cyc();
    req_valid = 4'b0000;
    drain();

    // Request raised during WAIT waits for the first IDLE cycle.
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'b0000;
    for (int i = 0; i < 20; i++) cyc();
    req_valid = 4'b0100;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      #1;
      chk("r26_hold", req_ready, 4'b0000);
      n++;
      cyc();
    end
    #1;
    chk("r26_grant", req_ready, 4'b0100);
    cyc();
    req_valid = 4'b0000;
    drain();

    // One-cycle pulse while busy is never granted.
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'b0000;
    for (int i = 0; i < 10; i++) cyc();
    req_valid = 4'b0010;
    cyc();
    req_valid = 4'b0000;
    drain();
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      if (uart_tx_start === 1'b1 || req_ready !== 4'b0000) sc++;
      cyc();
    end
    chk("r28_no_grant", sc, 0);

    // Reset 50 cycles into a frame aborts it.
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'b0000;
    for (int i = 0; i < 50; i++) cyc();
    reset = 1'b1;
    tick();
    chk("r27_busy", busy, 1'b0);
    chk("r27_start", uart_tx_start, 1'b0);
    chk("r27_gid", grant_id, 2'd3);
    reset       = 1'b0;
    m_last      = N - 1;
    m_busy_left = 0;
    sc = 0;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx_start === 1'b1) sc++;
      cyc();
    end
    chk("r27_no_start", sc, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
      req_data = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
